button_debounce: RTL
====================

// Module: button_debounce
// PURPOSE
//  Front end for the board push-buttons (BUT1/BUT2) ahead of the be8 core and its set/reset logic.
//  Synchronises the raw pins, debounces them against a shared slow tick, and produces clean levels.
//  Also produces one-cycle press, release and long-press event pulses.
//  Replaces the raw ~BUTn inversion in the top level.
// PARAMETERS
//  N_BTN        2      number of independent button channels
//  ACTIVE_LOW   1      1: pin reads 0 when pressed; 0: pin reads 1 when pressed
//  TICK_DIV     4096   clk cycles per debounce tick (100 MHz / 4096 ~ 24.4 kHz)
//  STABLE_TICKS 240    consecutive ticks of steady input to accept a change (~10 ms)
//  LONG_TICKS   24414  ticks held (after press accepted) before long_press (~1 s)
// PORTS
//  clk         in   1      system clock; all logic on rising edge
//  rst         in   1      asynchronous, active-high reset
//  btn_raw     in   N_BTN  raw asynchronous button pins
//  btn_level   out  N_BTN  debounced state, 1 = pressed
//  btn_press   out  N_BTN  1-cycle pulse when a press is accepted
//  btn_release out  N_BTN  1-cycle pulse when a release is accepted
//  btn_long    out  N_BTN  1-cycle pulse, at most once per press, after LONG_TICKS held
//  tick        out  1      1-cycle debounce tick strobe, for reuse by other slow logic
// BEHAVIOUR
//  Reset: all outputs 0, every FSM in IDLE, prescaler 0, counters 0.
//   Synchroniser flops reset to the released pin level (1 when ACTIVE_LOW).
//  Sync: 2-flop synchroniser per bit, then polarity-normalised to act (1 = pressed).
//  Prescaler: counts 0..TICK_DIV-1 and wraps to 0.
//   tick=1 for exactly the cycle the count equals TICK_DIV-1.
//  Per channel: state {IDLE,PRESS_WAIT,HELD,RELEASE_WAIT}, tick counter cnt, flag long_done.
//   cnt width is $clog2(LONG_TICKS+1).
//  IDLE: act=1 -> PRESS_WAIT, cnt=0.
//  PRESS_WAIT: act=0 on any cycle -> IDLE (bounce abort, no pulse).
//   On tick with act=1: cnt+1. When cnt+1==STABLE_TICKS: -> HELD, level=1, press pulse, cnt=0.
//  HELD: act=0 -> RELEASE_WAIT, cnt=0.
//   On tick with act=1: cnt increments, saturating at LONG_TICKS.
//   When cnt reaches LONG_TICKS and !long_done: long pulse, long_done=1.
//  RELEASE_WAIT: act=1 on any cycle -> HELD, cnt=0, level stays 1, long_done kept (no re-fire).
//   On tick with act=0: cnt+1. When cnt+1==STABLE_TICKS: -> IDLE, level=0, release pulse, long_done=0.
//  All outputs are registered. Pulses are high for exactly one clk.
//  press and release can never assert in the same cycle on one channel.
//  Latency, raw edge to press/release pulse: >= 2+(STABLE_TICKS-1)*TICK_DIV and <= 3+STABLE_TICKS*TICK_DIV clks.
//  Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.
//  Async rst mid-operation: immediate return to reset values.
//   A button held through reset is accepted as a new press STABLE_TICKS after rst falls.
//  Legal parameter range: TICK_DIV>=2, STABLE_TICKS>=1, LONG_TICKS>=1.
//   Outside this range is unsupported; an elaboration-time check flags it in simulation.
// TESTING (bench params: N_BTN=2, ACTIVE_LOW=1, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=10)
//  1 Reset: hold rst with btn_raw=2'b11 -> all outputs 0; tick first pulses at clk 4 after rst falls, then every 4 clks.
//  2 Clean press: btn_raw[0]=0 held -> one btn_press[0] pulse 10..15 clks later, btn_level[0]=1, channel 1 silent.
//  3 Bounce: toggle btn_raw[0] every 3 clks for 40 clks, then leave it at 1 -> no pulses, btn_level stays 0.
//  4 Long press: hold btn_raw[1]=0 for 80 clks -> exactly 1 btn_press[1] and 1 btn_long[1] (40..44 clks after press).
//    Release -> 1 btn_release[1], btn_level[1]=0.
//  5 Release glitch: while HELD, pulse btn_raw[0]=1 for 5 clks -> stays HELD, no release, no second press or long pulse.
//  6 Reset mid-press: assert rst during PRESS_WAIT of ch0 and during HELD of ch1 -> outputs 0 at once.
//    With both buttons still held, two press pulses follow after rst is released.

Source files
------------

// File: rtl/button_debounce.sv
// Push-button front end: two-flop synchroniser, shared debounce prescaler,
// and one debounce FSM per channel producing a clean level plus
// press / release / long-press single-cycle event pulses.
module button_debounce #(
  parameter int N_BTN        = 2,
  parameter int ACTIVE_LOW   = 1,
  parameter int TICK_DIV     = 4096,
  parameter int STABLE_TICKS = 240,
  parameter int LONG_TICKS   = 24414
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             tick
);

  // state        | meaning
  // S_IDLE       | released, waiting for act=1
  // S_PRESS_WAIT | act=1 seen, counting stable ticks before accepting press
  // S_HELD       | press accepted, counting ticks toward long press
  // S_RELEASE_WAIT | act=0 seen, counting stable ticks before accepting release
  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_HELD         = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_MAX = (LONG_TICKS > STABLE_TICKS) ? LONG_TICKS : STABLE_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Synchroniser idles at the released pin level so reset looks like "not pressed".
  localparam logic [N_BTN-1:0] SYNC_RST = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

  if (TICK_DIV < 2 || STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_param
    $error("button_debounce: unsupported parameters (need TICK_DIV>=2, STABLE_TICKS>=1, LONG_TICKS>=1)");
  end

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] act;
  logic [PW-1:0]    pre_q;
  logic [PW-1:0]    pre_d;
  logic             tick_q;

  // Two-flop synchroniser on the raw asynchronous pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign act = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  // Prescaler next count: 0..TICK_DIV-1 then wrap.
  always_comb begin
    pre_d = pre_q + PW'(1);
    if (pre_q == PW'(TICK_DIV - 1)) begin
      pre_d = '0;
    end
  end

  // Prescaler and registered tick, high exactly while pre_q == TICK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= (pre_d == PW'(TICK_DIV - 1));
    end
  end

  assign tick = tick_q;

  for (genvar c = 0; c < N_BTN; c++) begin : g_ch
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          ld_q, ld_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          long_q, long_d;

    assign cnt_inc = cnt_q + CW'(1);

    // Debounce FSM next-state and event decode.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ld_d    = ld_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (act[c]) begin
            state_d = S_PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!act[c]) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (tick_q) begin
            if (cnt_inc == CW'(STABLE_TICKS)) begin
              state_d = S_HELD;
              level_d = 1'b1;
              press_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_HELD: begin
          if (!act[c]) begin
            state_d = S_RELEASE_WAIT;
            cnt_d   = '0;
          end else if (tick_q && (cnt_q != CW'(LONG_TICKS))) begin
            cnt_d = cnt_inc;
            if ((cnt_inc == CW'(LONG_TICKS)) && !ld_q) begin
              long_d = 1'b1;
              ld_d   = 1'b1;
            end
          end
        end
        S_RELEASE_WAIT: begin
          // A bounce back to pressed keeps long_done so the long event cannot re-fire.
          if (act[c]) begin
            state_d = S_HELD;
            cnt_d   = '0;
          end else if (tick_q) begin
            if (cnt_inc == CW'(STABLE_TICKS)) begin
              state_d = S_IDLE;
              level_d = 1'b0;
              rel_d   = 1'b1;
              ld_d    = 1'b0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        ld_q    <= 1'b0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ld_q    <= ld_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
      end
    end

    assign btn_level[c]   = level_q;
    assign btn_press[c]   = press_q;
    assign btn_release[c] = rel_q;
    assign btn_long[c]    = long_q;
  end

endmodule
